// File: rtl/cpu_pkg.sv
// Shared encodings for the microcoded 8-bit CPU: control-word field
// positions, bus source/destination selects, ALU operations and flag bits.
package cpu_pkg;

  // Control-word field positions (bits above CW_USED_BITS are reserved)
  localparam int OUT_SEL_LSB    = 0;
  localparam int LOAD_SEL_LSB   = 4;
  localparam int ALU_OP_LSB     = 8;
  localparam int LHS_SEL_LSB    = 12;
  localparam int RHS_SEL_LSB    = 14;
  localparam int FLAGS_LOAD_BIT = 16;
  localparam int PC_INC_BIT     = 17;
  localparam int ADDR_SRC_LSB   = 18;
  localparam int PC_LOAD_BIT    = 20;
  localparam int CW_USED_BITS   = 21;

  // Flag bit indices within fout / the flags register: {N,V,Z,C}
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  localparam int MEM_DEPTH = 65536;

  // Source placed on main_bus; codes 11-15 drive nothing
  typedef enum logic [3:0] {
    OUT_NONE  = 4'd0,
    OUT_A     = 4'd1,
    OUT_B     = 4'd2,
    OUT_C     = 4'd3,
    OUT_D     = 4'd4,
    OUT_ALU   = 4'd5,
    OUT_MEM   = 4'd6,
    OUT_PC_LO = 4'd7,
    OUT_PC_HI = 4'd8,
    OUT_FLAGS = 4'd9,
    OUT_IR    = 4'd10
  } out_sel_e;

  // Destination loaded from main_bus; codes 10-15 load nothing
  typedef enum logic [3:0] {
    LD_NONE  = 4'd0,
    LD_A     = 4'd1,
    LD_B     = 4'd2,
    LD_C     = 4'd3,
    LD_D     = 4'd4,
    LD_MEM   = 4'd5,
    LD_IR    = 4'd6,
    LD_PC_LO = 4'd7,
    LD_PC_HI = 4'd8,
    LD_FLAGS = 4'd9
  } load_sel_e;

  // ALU operations; codes 12-15 pass lhs through
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_ADC = 4'd1,
    ALU_SUB = 4'd2,
    ALU_SBC = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_NOT = 4'd7,
    ALU_SHL = 4'd8,
    ALU_SHR = 4'd9,
    ALU_INC = 4'd10,
    ALU_DEC = 4'd11
  } alu_op_e;

  // Source placed on addr_bus
  typedef enum logic [1:0] {
    ADDR_NONE     = 2'd0,
    ADDR_PC       = 2'd1,
    ADDR_CD       = 2'd2,
    ADDR_NONE_ALT = 2'd3
  } addr_src_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU. Carry flag holds carry-out for additions, borrow
// for subtractions/decrement, and the shifted-out bit for shifts.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [7:0] lhs,
  input  logic [7:0] rhs,
  input  logic       cin,
  input  logic [3:0] op,
  output logic [7:0] result,
  output logic [3:0] flags
);

  logic [8:0] wide;
  logic       carry;
  logic       ovf;

  // Compute result, carry/borrow and signed overflow, then derive N/Z
  always_comb begin
    wide   = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    result = lhs;
    case (alu_op_e'(op))
      ALU_ADD: begin
        wide   = {1'b0, lhs} + {1'b0, rhs};
        result = wide[7:0];
        carry  = wide[8];
        ovf    = (lhs[7] == rhs[7]) && (wide[7] != lhs[7]);
      end
      ALU_ADC: begin
        wide   = {1'b0, lhs} + {1'b0, rhs} + {8'b0, cin};
        result = wide[7:0];
        carry  = wide[8];
        ovf    = (lhs[7] == rhs[7]) && (wide[7] != lhs[7]);
      end
      ALU_SUB: begin
        wide   = {1'b0, lhs} - {1'b0, rhs};
        result = wide[7:0];
        carry  = wide[8];
        ovf    = (lhs[7] != rhs[7]) && (wide[7] != lhs[7]);
      end
      ALU_SBC: begin
        wide   = {1'b0, lhs} - {1'b0, rhs} - {8'b0, cin};
        result = wide[7:0];
        carry  = wide[8];
        ovf    = (lhs[7] != rhs[7]) && (wide[7] != lhs[7]);
      end
      ALU_AND: result = lhs & rhs;
      ALU_OR:  result = lhs | rhs;
      ALU_XOR: result = lhs ^ rhs;
      ALU_NOT: result = ~lhs;
      ALU_SHL: begin
        result = {lhs[6:0], 1'b0};
        carry  = lhs[7];
      end
      ALU_SHR: begin
        result = {1'b0, lhs[7:1]};
        carry  = lhs[0];
      end
      ALU_INC: begin
        wide   = {1'b0, lhs} + 9'd1;
        result = wide[7:0];
        carry  = wide[8];
        ovf    = (lhs == 8'h7F);
      end
      ALU_DEC: begin
        wide   = {1'b0, lhs} - 9'd1;
        result = wide[7:0];
        carry  = wide[8];
        ovf    = (lhs == 8'h80);
      end
      default: result = lhs;
    endcase
    flags         = '0;
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
    flags[FLAG_Z] = (result == 8'h00);
    flags[FLAG_N] = result[7];
  end

endmodule

// File: rtl/cpu.sv
// Microcoded 8-bit CPU datapath: four general registers, 16-bit PC,
// instruction register, flags and 64 KiB memory joined by a shared
// tri-state data bus and address bus. Each cycle's control word picks
// one bus source and one bus destination.
module cpu
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        iclk,
  input  logic        ctrlen,
  input  logic [31:0] control_word,
  inout  wire  [7:0]  main_bus,
  inout  wire  [15:0] addr_bus,
  output logic [3:0]  fout,
  output logic [7:0]  iout
);

  logic [CW_USED_BITS-1:0] cw;
  logic                    reserved_unused;

  out_sel_e   out_sel;
  load_sel_e  load_sel;
  addr_src_e  addr_src;
  logic [3:0] alu_op;
  logic [1:0] lhs_sel;
  logic [1:0] rhs_sel;
  logic       flags_load;
  logic       pc_inc;
  logic       pc_load;

  logic [7:0]  gpr [4];
  logic [15:0] pc;
  logic [7:0]  ir;
  logic [3:0]  flags;
  logic [7:0]  mem [MEM_DEPTH];

  logic [7:0]  alu_lhs;
  logic [7:0]  alu_rhs;
  logic [7:0]  alu_result;
  logic [3:0]  alu_flags;
  logic [7:0]  mem_rdata;
  logic [7:0]  bus_out;
  logic        bus_en;
  logic [15:0] addr_out;
  logic        addr_en;

  // With ctrlen low the CPU sees a NOP word; reserved bits never matter
  assign cw              = ctrlen ? control_word[CW_USED_BITS-1:0] : '0;
  assign reserved_unused = ^control_word[31:CW_USED_BITS];

  assign out_sel    = out_sel_e'(cw[OUT_SEL_LSB +: 4]);
  assign load_sel   = load_sel_e'(cw[LOAD_SEL_LSB +: 4]);
  assign alu_op     = cw[ALU_OP_LSB +: 4];
  assign lhs_sel    = cw[LHS_SEL_LSB +: 2];
  assign rhs_sel    = cw[RHS_SEL_LSB +: 2];
  assign flags_load = cw[FLAGS_LOAD_BIT];
  assign pc_inc     = cw[PC_INC_BIT];
  assign addr_src   = addr_src_e'(cw[ADDR_SRC_LSB +: 2]);
  assign pc_load    = cw[PC_LOAD_BIT];

  assign alu_lhs = gpr[lhs_sel];
  assign alu_rhs = gpr[rhs_sel];

  cpu_alu u_alu (
    .lhs    (alu_lhs),
    .rhs    (alu_rhs),
    .cin    (flags[FLAG_C]),
    .op     (alu_op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Memory is addressed by whatever is on addr_bus, including external drivers
  assign mem_rdata = mem[addr_bus];

  // Pick the address-bus source; only PC and {C,D} actually drive it
  always_comb begin
    addr_out = '0;
    addr_en  = 1'b0;
    case (addr_src)
      ADDR_PC: begin
        addr_out = pc;
        addr_en  = 1'b1;
      end
      ADDR_CD: begin
        addr_out = {gpr[2], gpr[3]};
        addr_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // Pick the main-bus source; unused codes leave the bus released
  always_comb begin
    bus_out = '0;
    bus_en  = 1'b1;
    case (out_sel)
      OUT_A:     bus_out = gpr[0];
      OUT_B:     bus_out = gpr[1];
      OUT_C:     bus_out = gpr[2];
      OUT_D:     bus_out = gpr[3];
      OUT_ALU:   bus_out = alu_result;
      OUT_MEM:   bus_out = mem_rdata;
      OUT_PC_LO: bus_out = pc[7:0];
      OUT_PC_HI: bus_out = pc[15:8];
      OUT_FLAGS: bus_out = {4'b0000, flags};
      OUT_IR:    bus_out = ir;
      default:   bus_en  = 1'b0;
    endcase
  end

  assign main_bus = bus_en  ? bus_out  : 8'hzz;
  assign addr_bus = addr_en ? addr_out : 16'hzzzz;

  assign fout = flags;
  assign iout = ir;

  // Register, PC and flag updates; iclk high reserves the edge for IR fetch
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) gpr[i] <= '0;
      pc    <= '0;
      ir    <= '0;
      flags <= '0;
    end else if (iclk) begin
      if (load_sel == LD_IR) ir <= main_bus;
    end else begin
      case (load_sel)
        LD_A:     gpr[0] <= main_bus;
        LD_B:     gpr[1] <= main_bus;
        LD_C:     gpr[2] <= main_bus;
        LD_D:     gpr[3] <= main_bus;
        LD_FLAGS: if (!flags_load) flags <= main_bus[3:0];
        default:  ;
      endcase
      if (flags_load) flags <= alu_flags;
      if (pc_load)                    pc       <= addr_bus;
      else if (load_sel == LD_PC_LO)  pc[7:0]  <= main_bus;
      else if (load_sel == LD_PC_HI)  pc[15:8] <= main_bus;
      else if (pc_inc)                pc       <= pc + 16'd1;
    end
  end

  // Memory writes; contents survive reset
  always_ff @(posedge clk) begin
    if (rst && !iclk && (load_sel == LD_MEM)) mem[addr_bus] <= main_bus;
  end

endmodule

// File: tb/tb_cpu.sv
// Randomized scoreboard bench for cpu. A behavioural model predicts bus,
// flag and IR values each cycle; a monitor compares them mid-cycle.
module tb_cpu;
  import cpu_pkg::*;

  localparam int K_MAIN = 0;
  localparam int K_ADDR = 1;
  localparam int K_FOUT = 2;
  localparam int K_IOUT = 3;

  typedef struct {
    int cyc;
    int kind;
    int value;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iclk;
  logic        ctrlen;
  logic [31:0] control_word;
  wire  [7:0]  main_bus;
  wire  [15:0] addr_bus;
  logic [3:0]  fout;
  logic [7:0]  iout;

  logic [7:0]  ext_data;
  logic        ext_data_en;
  logic [15:0] ext_addr;
  logic        ext_addr_en;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [15:0] mon_act;

  // Behavioural model state
  int m_gpr [4];
  int m_pc;
  int m_ir;
  int m_flags;
  int m_mem [int];

  assign main_bus = ext_data_en ? ext_data : 8'hzz;
  assign addr_bus = ext_addr_en ? ext_addr : 16'hzzzz;

  // Pull-ups make a released bus read as all-ones
  for (genvar g = 0; g < 8; g++) begin : g_pu_main
    pullup (main_bus[g]);
  end
  for (genvar g = 0; g < 16; g++) begin : g_pu_addr
    pullup (addr_bus[g]);
  end

  cpu dut (
    .clk          (clk),
    .rst          (rst),
    .iclk         (iclk),
    .ctrlen       (ctrlen),
    .control_word (control_word),
    .main_bus     (main_bus),
    .addr_bus     (addr_bus),
    .fout         (fout),
    .iout         (iout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic string kind_name(input int k);
    case (k)
      K_MAIN:  return "main_bus";
      K_ADDR:  return "addr_bus";
      K_FOUT:  return "fout";
      default: return "iout";
    endcase
  endfunction

  function automatic logic [31:0] mk_cw(input int os, input int ls, input int op,
                                        input int lh, input int rh, input int fl,
                                        input int inc, input int src, input int pcl);
    return 32'(os) | (32'(ls) << 4) | (32'(op) << 8) | (32'(lh) << 12) |
           (32'(rh) << 14) | (32'(fl) << 16) | (32'(inc) << 17) |
           (32'(src) << 18) | (32'(pcl) << 20);
  endfunction

  // ALU behaviour from the arithmetic definitions on unsigned/signed integers
  function automatic void alu_model(input int op, input int l, input int r, input int cin,
                                    output int res, output int flg);
    int sl, sr, full, sfull, c, v;
    sl = (l > 127) ? l - 256 : l;
    sr = (r > 127) ? r - 256 : r;
    c = 0;
    v = 0;
    sfull = 0;
    case (op)
      0:  begin full = l + r;       sfull = sl + sr;       c = (full > 255); end
      1:  begin full = l + r + cin; sfull = sl + sr + cin; c = (full > 255); end
      2:  begin full = l - r;       sfull = sl - sr;       c = (full < 0);   end
      3:  begin full = l - r - cin; sfull = sl - sr - cin; c = (full < 0);   end
      4:  full = l & r;
      5:  full = l | r;
      6:  full = l ^ r;
      7:  full = 255 - l;
      8:  begin full = l * 2; c = (l >= 128); end
      9:  begin full = l / 2; c = l % 2;      end
      10: begin full = l + 1; sfull = sl + 1; c = (full > 255); end
      11: begin full = l - 1; sfull = sl - 1; c = (full < 0);   end
      default: full = l;
    endcase
    if (op <= 3 || op == 10 || op == 11) v = (sfull > 127 || sfull < -128);
    res = full & 255;
    flg = ((res >= 128) ? 8 : 0) + v * 4 + ((res == 0) ? 2 : 0) + c;
  endfunction

  // Queue an expected observation for the current cycle
  task automatic checkOutput(input int kind, input int value);
    exp_t e;
    e.cyc   = cyc;
    e.kind  = kind;
    e.value = value;
    sb_q.push_back(e);
  endtask

  // Predict this cycle's observable values and the state after the next edge
  task automatic modelCycle(input logic r, input logic i, input logic en, input logic [31:0] cw,
                            input logic dden, input logic [7:0] dd,
                            input logic aden, input logic [15:0] ad);
    int cwv, os, ls, op, lh, rh, fl, inc, src, pcl, addr, bus, res, flg;
    bit bus_known;
    cwv = en ? int'(cw & 32'h001F_FFFF) : 0;
    os  = cwv % 16;
    ls  = (cwv / 16) % 16;
    op  = (cwv / 256) % 16;
    lh  = (cwv / 4096) % 4;
    rh  = (cwv / 16384) % 4;
    fl  = (cwv / 65536) % 2;
    inc = (cwv / 131072) % 2;
    src = (cwv / 262144) % 4;
    pcl = (cwv / 1048576) % 2;
    alu_model(op, m_gpr[lh], m_gpr[rh], m_flags % 2, res, flg);
    if (src == 1)      addr = m_pc;
    else if (src == 2) addr = m_gpr[2] * 256 + m_gpr[3];
    else if (aden)     addr = int'(ad);
    else               addr = 65535;
    bus_known = 1;
    case (os)
      1, 2, 3, 4: bus = m_gpr[os - 1];
      5:  bus = res;
      6:  if (m_mem.exists(addr)) bus = m_mem[addr]; else begin bus = 0; bus_known = 0; end
      7:  bus = m_pc % 256;
      8:  bus = m_pc / 256;
      9:  bus = m_flags;
      10: bus = m_ir;
      default: bus = dden ? int'(dd) : 255;
    endcase
    if (bus_known) checkOutput(K_MAIN, bus);
    checkOutput(K_ADDR, addr);
    checkOutput(K_FOUT, m_flags);
    checkOutput(K_IOUT, m_ir);
    if (!r) begin
      for (int k = 0; k < 4; k++) m_gpr[k] = 0;
      m_pc = 0;
      m_ir = 0;
      m_flags = 0;
    end else if (i) begin
      if (ls == 6) m_ir = bus;
    end else begin
      if (ls >= 1 && ls <= 4) m_gpr[ls - 1] = bus;
      if (ls == 5) m_mem[addr] = bus;
      if (ls == 9) m_flags = bus % 16;
      if (fl == 1) m_flags = flg;
      if (pcl == 1)     m_pc = addr;
      else if (ls == 7) m_pc = (m_pc / 256) * 256 + bus;
      else if (ls == 8) m_pc = bus * 256 + (m_pc % 256);
      else if (inc == 1) m_pc = (m_pc + 1) % 65536;
    end
  endtask

  // Drive one cycle of inputs, record predictions, then advance past the edge
  task automatic applyStimulus(input logic r, input logic i, input logic en, input logic [31:0] cw,
                               input logic dden, input logic [7:0] dd,
                               input logic aden, input logic [15:0] ad);
    rst          = r;
    iclk         = i;
    ctrlen       = en;
    control_word = cw;
    ext_data_en  = dden;
    ext_data     = dd;
    ext_addr_en  = aden;
    ext_addr     = ad;
    modelCycle(r, i, en, cw, dden, dd, aden, ad);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] cw, input logic dden, input logic [7:0] dd);
    applyStimulus(1'b1, 1'b0, 1'b1, cw, dden, dd, 1'b0, 16'h0000);
  endtask

  // One random cycle, avoiding bus contention and unpredictable memory reads
  task automatic runRandom();
    logic [31:0] cw;
    logic        r, i, en, dden, aden;
    logic [7:0]  dd;
    logic [15:0] ad;
    int          os, ls, src, addr;
    cw   = $urandom();
    en   = ($urandom_range(0, 9) != 0);
    i    = ($urandom_range(0, 4) == 0);
    r    = ($urandom_range(0, 39) != 0);
    dd   = 8'($urandom());
    ad   = 16'($urandom_range(0, 31));
    os   = int'(cw[3:0]);
    ls   = int'(cw[7:4]);
    src  = int'(cw[19:18]);
    aden = 1'b0;
    if (en) begin
      if (ls == 9) cw[16] = 1'b0;
      if (src == 0 || src == 3)
        aden = (os == 6) || (ls == 5) || cw[20] || ($urandom_range(0, 1) == 1);
      if (os == 6) begin
        if (src == 1)      addr = m_pc;
        else if (src == 2) addr = m_gpr[2] * 256 + m_gpr[3];
        else               addr = int'(ad);
        if (!m_mem.exists(addr)) begin
          cw[3:0] = 4'd0;
          os = 0;
        end
      end
      dden = !(os >= 1 && os <= 10) && ((ls >= 1 && ls <= 9) || ($urandom_range(0, 1) == 1));
    end else begin
      aden = ($urandom_range(0, 1) == 1);
      dden = ($urandom_range(0, 1) == 1);
    end
    applyStimulus(r, i, en, cw, dden, dd, aden, ad);
  endtask

  // Monitor: compare queued predictions mid-cycle, away from the clock edge
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      case (mon_e.kind)
        K_MAIN:  mon_act = {8'h00, main_bus};
        K_ADDR:  mon_act = addr_bus;
        K_FOUT:  mon_act = {12'h000, fout};
        default: mon_act = {8'h00, iout};
      endcase
      checks++;
      if (mon_e.cyc != cyc || mon_act !== 16'(mon_e.value)) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h",
                 kind_name(mon_e.kind), mon_e.cyc, mon_act, mon_e.value);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0; iclk = 1'b0; ctrlen = 1'b1; control_word = '0;
    ext_data_en = 1'b0; ext_data = '0; ext_addr_en = 1'b0; ext_addr = '0;
    for (int k = 0; k < 4; k++) m_gpr[k] = 0;
    m_pc = 0; m_ir = 0; m_flags = 0;
    @(posedge clk);
    #1;

    // Reset state and released buses
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 16'h0000);
    checkOutput(K_MAIN, 'hFF);
    checkOutput(K_ADDR, 'hFFFF);
    checkOutput(K_FOUT, 0);
    checkOutput(K_IOUT, 0);
    step(32'h0, 1'b0, 8'h00);

    // External load into A, then drive A
    step(mk_cw(0, LD_A, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'h3C);
    checkOutput(K_MAIN, 'h3C);
    step(mk_cw(OUT_A, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 8'h00);

    // Signed overflow on add
    step(mk_cw(0, LD_B, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'h01);
    step(mk_cw(0, LD_A, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'h7F);
    checkOutput(K_MAIN, 'h80);
    step(mk_cw(OUT_ALU, 0, ALU_ADD, 0, 1, 1, 0, 0, 0), 1'b0, 8'h00);
    checkOutput(K_FOUT, 'hC);
    step(32'h0, 1'b0, 8'h00);

    // Zero result on subtract
    step(mk_cw(0, LD_A, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'h55);
    step(mk_cw(0, LD_B, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'h55);
    checkOutput(K_MAIN, 'h00);
    step(mk_cw(OUT_ALU, 0, ALU_SUB, 0, 1, 1, 0, 0, 0), 1'b0, 8'h00);
    checkOutput(K_FOUT, 'h2);
    step(32'h0, 1'b0, 8'h00);

    // PC wraps from 0xFFFF to 0x0000
    step(mk_cw(0, LD_PC_LO, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'hFF);
    step(mk_cw(0, LD_PC_HI, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'hFF);
    checkOutput(K_ADDR, 'hFFFF);
    step(mk_cw(0, 0, 0, 0, 0, 0, 1, ADDR_PC, 0), 1'b0, 8'h00);
    checkOutput(K_ADDR, 'h0000);
    step(mk_cw(0, 0, 0, 0, 0, 0, 0, ADDR_PC, 0), 1'b0, 8'h00);

    // IR loads only on an iclk-high edge
    step(mk_cw(0, LD_IR, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'hA5);
    checkOutput(K_IOUT, 'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, mk_cw(0, LD_IR, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'hA5, 1'b0, 16'h0000);
    checkOutput(K_IOUT, 'hA5);
    step(32'h0, 1'b0, 8'h00);

    // Memory write and read back through {C,D}
    step(mk_cw(0, LD_C, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'h12);
    step(mk_cw(0, LD_D, 0, 0, 0, 0, 0, 0, 0), 1'b1, 8'h34);
    step(mk_cw(0, LD_MEM, 0, 0, 0, 0, 0, ADDR_CD, 0), 1'b1, 8'h99);
    checkOutput(K_MAIN, 'h99);
    checkOutput(K_ADDR, 'h1234);
    step(mk_cw(OUT_MEM, 0, 0, 0, 0, 0, 0, ADDR_CD, 0), 1'b0, 8'h00);

    // ctrlen low turns the word into a NOP
    applyStimulus(1'b1, 1'b0, 1'b0, mk_cw(OUT_A, LD_B, 0, 0, 0, 0, 1, ADDR_PC, 0),
                  1'b1, 8'h5A, 1'b0, 16'h0000);
    checkOutput(K_MAIN, 'h55);
    step(mk_cw(OUT_B, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 8'h00);

    // Reset wins over a requested load and increment
    applyStimulus(1'b0, 1'b0, 1'b1, mk_cw(0, LD_A, 0, 0, 0, 0, 1, 0, 0), 1'b1, 8'h77, 1'b0, 16'h0000);
    checkOutput(K_MAIN, 'h00);
    checkOutput(K_ADDR, 'h0000);
    step(mk_cw(OUT_A, 0, 0, 0, 0, 0, 0, ADDR_PC, 0), 1'b0, 8'h00);

    // Seed a small memory window through an external address
    for (int a = 0; a < 32; a++)
      applyStimulus(1'b1, 1'b0, 1'b1, mk_cw(0, LD_MEM, 0, 0, 0, 0, 0, 0, 0),
                    1'b1, 8'($urandom()), 1'b1, 16'(a));

    for (int n = 0; n < 2000; n++) runRandom();

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 16'h0000);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
